// File: rtl/seq_mult_digit_if.sv
// Handshake and operand/result bundle for seq_mult_digit.
// The optional signed_mode wire exists only when SIGNED_MODE_EN is defined.
interface seq_mult_digit_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       dataa;
    logic [WIDTH-1:0]       datab;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
`ifdef SIGNED_MODE_EN
    logic                   signed_mode;
`endif

    modport master (
        output start,
        output dataa,
        output datab,
`ifdef SIGNED_MODE_EN
        output signed_mode,
`endif
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  dataa,
        input  datab,
`ifdef SIGNED_MODE_EN
        input  signed_mode,
`endif
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_mult_digit.sv
// Sequential digit-serial shift-add multiplier.
// Operands are split into DIGIT-bit digits; one DIGIT x DIGIT partial product
// is formed, shifted into place and accumulated per clock (N*N clocks total).
// Optional build macro: SIGNED_MODE_EN adds a signed_mode input that selects
// two's-complement operands (sign/magnitude around the unsigned digit loop).
module seq_mult_digit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_mult_digit_if.slave   bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(2 * WIDTH) + 1;
    localparam int PW    = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [1:0]         state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [IDX_W-1:0]   i_r;
    logic [IDX_W-1:0]   j_r;
    logic [PW-1:0]      acc_r;
    logic [PW-1:0]      product_r;
    logic               busy_r;
    logic               done_r;

    logic [DIGIT-1:0]   a_dig_s;
    logic [DIGIT-1:0]   b_dig_s;
    logic [2*DIGIT-1:0] pp_s;
    logic [SH_W-1:0]    shift_s;
    logic [PW-1:0]      term_s;
    logic [PW-1:0]      sum_s;
    logic [PW-1:0]      result_s;
    logic [WIDTH-1:0]   a_cap_s;
    logic [WIDTH-1:0]   b_cap_s;
    logic               accept_s;

`ifdef SIGNED_MODE_EN
    logic               neg_r;
    logic               neg_cap_s;

    // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic en);
        if (en && v[WIDTH-1]) begin
            magnitude = (~v) + WIDTH'(1);
        end else begin
            magnitude = v;
        end
    endfunction
`endif

    // A new operation can only be taken when no calculation is in flight.
    always_comb begin
        accept_s = 1'b0;
        if (bus.start && (state_r != ST_CALC)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Operand values to capture; magnitudes are taken when signed mode is on.
    always_comb begin
`ifdef SIGNED_MODE_EN
        a_cap_s   = magnitude(bus.dataa, bus.signed_mode);
        b_cap_s   = magnitude(bus.datab, bus.signed_mode);
        neg_cap_s = bus.signed_mode & (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
`else
        a_cap_s   = bus.dataa;
        b_cap_s   = bus.datab;
`endif
    end

    // Current digit pair, its partial product placed at DIGIT*(i+j), and the running sum.
    always_comb begin
        a_dig_s  = a_r[i_r*DIGIT +: DIGIT];
        b_dig_s  = b_r[j_r*DIGIT +: DIGIT];
        pp_s     = (2*DIGIT)'(a_dig_s) * (2*DIGIT)'(b_dig_s);
        shift_s  = SH_W'(DIGIT) * (SH_W'(i_r) + SH_W'(j_r));
        term_s   = PW'(pp_s) << shift_s;
        sum_s    = acc_r + term_s;
`ifdef SIGNED_MODE_EN
        if (neg_r) begin
            result_s = (~sum_s) + PW'(1);
        end else begin
            result_s = sum_s;
        end
`else
        result_s = sum_s;
`endif
    end

    // Control FSM, digit indices, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            i_r       <= '0;
            j_r       <= '0;
            acc_r     <= '0;
            product_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef SIGNED_MODE_EN
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        a_r     <= a_cap_s;
                        b_r     <= b_cap_s;
`ifdef SIGNED_MODE_EN
                        neg_r   <= neg_cap_s;
`endif
                        acc_r   <= '0;
                        i_r     <= '0;
                        j_r     <= '0;
                        state_r <= ST_CALC;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_r <= sum_s;
                    if (j_r == IDX_LAST) begin
                        j_r <= '0;
                        if (i_r == IDX_LAST) begin
                            product_r <= result_s;
                            state_r   <= ST_DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            i_r <= i_r + IDX_W'(1);
                        end
                    end else begin
                        j_r <= j_r + IDX_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

endmodule

// File: tb/tb_seq_mult_digit.sv
// Self-checking bench for seq_mult_digit: default 8x8/2 instance plus a 4x4/2
// instance. Expected products come from a behavioural multiply model and are
// queued when a start is driven, then popped when done is seen.
module tb_seq_mult_digit;
    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp8_q[$];
    logic [7:0]  exp4_q[$];

    seq_mult_digit_if #(.WIDTH(8)) bus8();
    seq_mult_digit_if #(.WIDTH(4)) bus4();

    seq_mult_digit #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    seq_mult_digit #(.WIDTH(4), .DIGIT(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic sm);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        if (sm) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            model8 = 16'(sa * sb);
        end else begin
            model8 = {8'h00, a} * {8'h00, b};
        end
    endfunction

    // Drive one start on the 8-bit DUT; returns at posedge+1 of the accepting edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input bit hold);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.dataa = a;
        bus8.datab = b;
`ifdef SIGNED_MODE_EN
        bus8.signed_mode = sm;
`endif
        exp8_q.push_back(model8(a, b, sm));
        @(posedge clk);
        #1;
        if (!hold) bus8.start = 1'b0;
    endtask

    task automatic start4(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.dataa = a;
        bus4.datab = b;
        exp4_q.push_back({4'h0, a} * {4'h0, b});
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
    endtask

    // Wait (bounded) for done on the 8-bit DUT, counting busy cycles seen.
    task automatic wait_done8(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus8.done) begin
                seen = 1'b1;
                break;
            end
            if (bus8.busy) cycles++;
        end
    endtask

    task automatic wait_done4(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus4.done) begin
                seen = 1'b1;
                break;
            end
            if (bus4.busy) cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.dataa = '0; bus8.datab = '0;
        bus4.start = 1'b0; bus4.dataa = '0; bus4.datab = '0;
`ifdef SIGNED_MODE_EN
        bus8.signed_mode = 1'b0;
        bus4.signed_mode = 1'b0;
`endif
        #22;
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus8.busy); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus8.done); end
        checks++; if (bus8.product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h want 0000", bus8.product); end
        checks++; if (bus4.product !== 8'h00) begin errors++; $display("FAIL reset_product4: got %h want 00", bus4.product); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_max_operands();
        int cyc; bit seen; logic [15:0] exp;
        start8(8'hFF, 8'hFF, 1'b0, 1'b0);
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL max_busy_start: got %b want 1", bus8.busy); end
        checks++; if (bus8.product !== 16'h0000) begin errors++; $display("FAIL max_product_held: got %h want 0000", bus8.product); end
        wait_done8(cyc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL max_done_timeout: got no done want done"); end
        checks++; if (cyc !== 16) begin errors++; $display("FAIL max_busy_cycles: got %0d want 16", cyc); end
        exp = exp8_q.pop_front();
        checks++; if (bus8.product !== exp) begin errors++; $display("FAIL max_product: got %h want %h", bus8.product, exp); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL max_busy_in_done: got %b want 0", bus8.busy); end
        @(negedge clk);
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL max_done_pulse: got %b want 0", bus8.done); end
        repeat (3) @(negedge clk);
        checks++; if (bus8.product !== 16'hFE01) begin errors++; $display("FAIL max_product_hold: got %h want fe01", bus8.product); end
    endtask

    task automatic test_width4();
        int cyc; bit seen; logic [7:0] exp;
        start4(4'd13, 4'd11);
        wait_done4(cyc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL w4_done_timeout: got no done want done"); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL w4_busy_cycles: got %0d want 4", cyc); end
        exp = exp4_q.pop_front();
        checks++; if (bus4.product !== exp) begin errors++; $display("FAIL w4_13x11: got %h want %h", bus4.product, exp); end
        start4(4'd15, 4'd15);
        wait_done4(cyc, seen);
        exp = exp4_q.pop_front();
        checks++; if (!seen || bus4.product !== exp) begin errors++; $display("FAIL w4_15x15: got %h want %h", bus4.product, exp); end
    endtask

    task automatic test_start_held();
        int cyc; int busy_cnt; bit seen; logic [15:0] exp;
        busy_cnt = 0;
        start8(8'h12, 8'h34, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus8.busy) busy_cnt++;
            if (k == 4) begin
                bus8.dataa = 8'hAA;
                bus8.datab = 8'h55;
            end
        end
        bus8.start = 1'b0;
        wait_done8(cyc, seen);
        busy_cnt += cyc;
        checks++; if (!seen || busy_cnt !== 16) begin errors++; $display("FAIL held_busy_cycles: got %0d want 16", busy_cnt); end
        exp = exp8_q.pop_front();
        checks++; if (bus8.product !== exp) begin errors++; $display("FAIL held_product: got %h want %h", bus8.product, exp); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; logic [15:0] exp;
        start8(8'h07, 8'h09, 1'b0, 1'b0);
        wait_done8(cyc, seen);
        exp = exp8_q.pop_front();
        checks++; if (!seen || bus8.product !== exp) begin errors++; $display("FAIL b2b_first: got %h want %h", bus8.product, exp); end
        bus8.start = 1'b1;
        bus8.dataa = 8'h03;
        bus8.datab = 8'h05;
        exp8_q.push_back(model8(8'h03, 8'h05, 1'b0));
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", bus8.busy); end
        checks++; if (bus8.product !== 16'h003F) begin errors++; $display("FAIL b2b_prev_held: got %h want 003f", bus8.product); end
        wait_done8(cyc, seen);
        checks++; if (!seen || cyc !== 16) begin errors++; $display("FAIL b2b_cycles: got %0d want 16", cyc); end
        exp = exp8_q.pop_front();
        checks++; if (bus8.product !== exp) begin errors++; $display("FAIL b2b_second: got %h want %h", bus8.product, exp); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen; logic [15:0] exp;
        start8(8'h55, 8'h66, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp8_q.pop_back());
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus8.busy); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", bus8.done); end
        checks++; if (bus8.product !== 16'h0000) begin errors++; $display("FAIL rstmid_product: got %h want 0000", bus8.product); end
        @(negedge clk);
        rst_n = 1'b1;
        start8(8'h10, 8'h10, 1'b0, 1'b0);
        wait_done8(cyc, seen);
        exp = exp8_q.pop_front();
        checks++; if (!seen || bus8.product !== exp) begin errors++; $display("FAIL rstmid_after: got %h want %h", bus8.product, exp); end
    endtask

    task automatic test_zero();
        int cyc; bit seen; logic [15:0] exp;
        start8(8'h00, 8'hAB, 1'b0, 1'b0);
        wait_done8(cyc, seen);
        checks++; if (!seen || cyc !== 16) begin errors++; $display("FAIL zero_cycles: got %0d want 16", cyc); end
        exp = exp8_q.pop_front();
        checks++; if (bus8.product !== exp) begin errors++; $display("FAIL zero_product: got %h want %h", bus8.product, exp); end
    endtask

    task automatic test_mixed_patterns();
        int cyc; bit seen; logic [15:0] exp;
        logic [7:0] va [4] = '{8'hA5, 8'h01, 8'h80, 8'h3C};
        logic [7:0] vb [4] = '{8'h5A, 8'hFF, 8'h02, 8'hC3};
        for (int k = 0; k < 4; k++) begin
            start8(va[k], vb[k], 1'b0, 1'b0);
            wait_done8(cyc, seen);
            exp = exp8_q.pop_front();
            checks++; if (!seen || bus8.product !== exp) begin errors++; $display("FAIL mixed_%0d: got %h want %h", k, bus8.product, exp); end
        end
    endtask

`ifdef SIGNED_MODE_EN
    task automatic test_signed();
        int cyc; bit seen; logic [15:0] exp;
        logic [7:0] va [4] = '{8'h80, 8'hFD, 8'h7F, 8'hFD};
        logic [7:0] vb [4] = '{8'h80, 8'h05, 8'h81, 8'h05};
        logic       vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            start8(va[k], vb[k], vs[k], 1'b0);
            wait_done8(cyc, seen);
            exp = exp8_q.pop_front();
            checks++; if (!seen || cyc !== 16 || bus8.product !== exp) begin errors++; $display("FAIL signed_%0d: got %h (%0d cycles) want %h (16 cycles)", k, bus8.product, cyc, exp); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_max_operands();
        test_width4();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        test_mixed_patterns();
`ifdef SIGNED_MODE_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
